igmp_report_scheduler: RTL and testbench

Host-side IGMP membership controller that sits after the IGMP receive parser and ahead of the IGMP transmit framer. It keeps a table of joined multicast groups and arms a randomised per-group response timer for each received membership query. When a timer expires, or a group is joined or left, it raises a transmit request. A single arbiter schedules all of these onto one valid/ready transmit interface.

---
 rtl/igmp_report_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_igmp_report_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/igmp_report_scheduler.sv
// IGMP host membership table with randomised per-group query response timers.
// Joins, leaves and timer expiries are arbitrated onto a single valid/ready transmit port.
module igmp_report_scheduler #(
    parameter int          NGRP      = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        q_valid,
    input  logic [7:0]  q_mrc,
    input  logic [31:0] q_group,
    input  logic        cmd_join,
    input  logic        cmd_leave,
    input  logic [31:0] cmd_group,
    output logic        cmd_ack,
    output logic        cmd_err,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_type,
    output logic [31:0] tx_group
);
    localparam int IW = (NGRP > 1) ? $clog2(NGRP) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state, state_nxt;
    logic [15:0]     lfsr;
    logic [7:0]      delay;
    logic [NGRP-1:0] slot_vld, slot_run, slot_rdy, q_hit;
    logic [31:0]     slot_addr  [NGRP];
    logic [7:0]      slot_timer [NGRP];
    logic            leave_pend;
    logic [31:0]     leave_addr;
    logic [IW-1:0]   rr, tx_slot, hit_idx, free_idx, pick_idx;
    logic            tx_leave, hit, free_found, pick_found;
    logic            join_ok, join_alloc, leave_ok, hs;

    // Taps 16,14,13,11; free-running so query delays decorrelate between hosts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= LFSR_SEED;
        else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign delay = 8'((16'(lfsr[7:0]) * (16'(q_mrc) + 16'd1)) >> 8);

    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        q_hit      = '0;
        for (int i = 0; i < NGRP; i++) begin
            if (slot_vld[i] && slot_addr[i] == cmd_group) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            q_hit[i] = q_valid && slot_vld[i] && (q_group == 32'd0 || slot_addr[i] == q_group);
        end
        // Descending scans so the lowest free slot / nearest slot after rr wins.
        for (int i = NGRP - 1; i >= 0; i--) begin
            if (!slot_vld[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (slot_rdy[(int'(rr) + i) % NGRP]) begin
                pick_found = 1'b1;
                pick_idx   = IW'((int'(rr) + i) % NGRP);
            end
        end
    end

    assign join_ok    = cmd_join && !cmd_leave && cmd_group != 32'd0 && hit;
    assign join_alloc = cmd_join && !cmd_leave && cmd_group != 32'd0 && !hit && free_found;
    assign leave_ok   = cmd_leave && !cmd_join && hit && !leave_pend;
    assign hs         = (state == SEND) && tx_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_ack <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            cmd_ack <= join_ok || join_alloc || leave_ok;
            cmd_err <= (cmd_join || cmd_leave) && !(join_ok || join_alloc || leave_ok);
        end
    end

    // NOTE: addresses are qualified by slot_vld, so this storage needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NGRP; i++)
            if (join_alloc && free_idx == IW'(i)) slot_addr[i] <= cmd_group;
    end

    // Later statements override earlier ones: handshake, then timers, then commands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_vld <= '0;
            slot_run <= '0;
            slot_rdy <= '0;
            for (int i = 0; i < NGRP; i++) slot_timer[i] <= 8'd0;
        end else begin
            for (int i = 0; i < NGRP; i++) begin
                if (hs && !tx_leave && tx_slot == IW'(i)) slot_rdy[i] <= 1'b0;
                if (q_hit[i] && (!slot_run[i] || delay < slot_timer[i])) begin
                    slot_timer[i] <= delay;
                    slot_run[i]   <= 1'b1;
                end else if (slot_run[i] && slot_timer[i] == 8'd0) begin
                    slot_rdy[i] <= 1'b1;
                    slot_run[i] <= 1'b0;
                end else if (slot_run[i] && tick) begin
                    slot_timer[i] <= slot_timer[i] - 8'd1;
                end
                if (join_alloc && free_idx == IW'(i)) begin
                    slot_vld[i]   <= 1'b1;
                    slot_rdy[i]   <= 1'b1;
                    slot_run[i]   <= 1'b0;
                    slot_timer[i] <= 8'd0;
                end
                if (leave_ok && hit_idx == IW'(i)) begin
                    slot_vld[i] <= 1'b0;
                    slot_run[i] <= 1'b0;
                    slot_rdy[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leave_pend <= 1'b0;
            leave_addr <= 32'd0;
            rr         <= '0;
        end else begin
            if (hs && tx_leave) leave_pend <= 1'b0;
            if (hs && !tx_leave) rr <= (tx_slot == IW'(NGRP - 1)) ? '0 : tx_slot + 1'b1;
            if (leave_ok) begin
                leave_pend <= 1'b1;
                leave_addr <= cmd_group;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (leave_pend || pick_found) state_nxt = SEND;
            SEND:    if (tx_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_valid = (state == SEND);
    end

    // Message fields are latched on entry to SEND so they stay stable until the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_type  <= 8'h00;
            tx_group <= 32'd0;
            tx_slot  <= '0;
            tx_leave <= 1'b0;
        end else if (state == IDLE && state_nxt == SEND) begin
            if (leave_pend) begin
                tx_leave <= 1'b1;
                tx_type  <= 8'h02;
                tx_group <= leave_addr;
            end else begin
                tx_leave <= 1'b0;
                tx_type  <= 8'h01;
                tx_group <= slot_addr[pick_idx];
                tx_slot  <= pick_idx;
            end
        end
    end
endmodule

// File: tb/tb_igmp_report_scheduler.sv
// Directed bench for igmp_report_scheduler: joins, queries, leaves, arbitration order and reset.
module tb_igmp_report_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0, q_valid = 1'b0;
    logic [7:0]  q_mrc = 8'd0;
    logic [31:0] q_group = 32'd0;
    logic        cmd_join = 1'b0, cmd_leave = 1'b0;
    logic [31:0] cmd_group = 32'd0;
    logic        cmd_ack, cmd_err, tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_type;
    logic [31:0] tx_group;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] GA = 32'hE000_0001, GB = 32'hE000_0002, GC = 32'hE000_0003;
    localparam logic [31:0] GD = 32'hE000_0004, GE = 32'hE000_0005, GX = 32'hE000_0009;

    igmp_report_scheduler #(.NGRP(4), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .tick(tick), .q_valid(q_valid), .q_mrc(q_mrc), .q_group(q_group),
        .cmd_join(cmd_join), .cmd_leave(cmd_leave), .cmd_group(cmd_group),
        .cmd_ack(cmd_ack), .cmd_err(cmd_err), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_type(tx_type), .tx_group(tx_group)
    );

    always #5 clk = ~clk;

    // Reference delay LFSR: taps 16,14,13,11, advancing every cycle out of reset.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [7:0] ref_delay(input logic [15:0] l, input logic [7:0] mrc);
        logic [15:0] p;
        p = {8'd0, l[7:0]} * ({8'd0, mrc} + 16'd1);
        return p[15:8];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic command(input string tag, input logic j, input logic l,
                           input logic [31:0] g, input logic exp_ack);
        cmd_join = j; cmd_leave = l; cmd_group = g;
        cyc();
        cmd_join = 1'b0; cmd_leave = 1'b0;
        check({tag, "_ack"}, {31'd0, cmd_ack}, {31'd0, exp_ack});
        check({tag, "_err"}, {31'd0, cmd_err}, {31'd0, !exp_ack});
    endtask

    task automatic wait_tx(input int maxc, output bit found);
        found = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (tx_valid) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic recv(input string tag, input logic [7:0] ty, input logic [31:0] grp);
        bit f;
        wait_tx(40, f);
        check({tag, "_seen"}, {31'd0, f}, 32'd1);
        if (f) begin
            check({tag, "_type"}, {24'd0, tx_type}, {24'd0, ty});
            check({tag, "_group"}, tx_group, grp);
            tx_ready = 1'b1;
            cyc();
            tx_ready = 1'b0;
            check({tag, "_drop"}, {31'd0, tx_valid}, 32'd0);
        end
    endtask

    task automatic no_tx(input string tag, input int n);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (tx_valid) seen = 1'b1;
            cyc();
        end
        check(tag, {31'd0, seen}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        cyc();
    endtask

    initial begin
        bit          f;
        int          cnt, tcnt, ticks_at;
        logic [31:0] cap_g [4];
        int          cap_t [4];
        logic [7:0]  cap_ty, d1, d2;

        // Reset state
        cyc(); cyc();
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_type", {24'd0, tx_type}, 32'd0);
        check("rst_group", tx_group, 32'd0);
        check("rst_ack", {30'd0, cmd_ack, cmd_err}, 32'd0);
        rst = 1'b1;
        cyc();

        // Single join, report held under backpressure
        command("join_a", 1'b1, 1'b0, GA, 1'b1);
        wait_tx(10, f);
        check("s1_seen", {31'd0, f}, 32'd1);
        check("s1_type", {24'd0, tx_type}, 32'h01);
        check("s1_group", tx_group, GA);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("hold_stable", {7'd0, tx_valid, tx_type, 16'd0}, {7'd0, 1'b1, 8'h01, 16'd0});
            check("hold_group", tx_group, GA);
        end
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        check("s1_drop", {31'd0, tx_valid}, 32'd0);

        // Fill the table, overflow, re-join
        command("join_b", 1'b1, 1'b0, GB, 1'b1);
        command("join_c", 1'b1, 1'b0, GC, 1'b1);
        command("join_d", 1'b1, 1'b0, GD, 1'b1);
        command("join_full", 1'b1, 1'b0, GE, 1'b0);
        command("join_zero", 1'b1, 1'b0, 32'd0, 1'b0);
        recv("rep_b", 8'h01, GB);
        recv("rep_c", 8'h01, GC);
        recv("rep_d", 8'h01, GD);
        command("rejoin_b", 1'b1, 1'b0, GB, 1'b1);
        no_tx("rejoin_no_rep", 10);

        // General query, zero max response: three reports in rr order, 2 cycles apart
        do_reset();
        command("j3_a", 1'b1, 1'b0, GA, 1'b1);
        command("j3_b", 1'b1, 1'b0, GB, 1'b1);
        command("j3_c", 1'b1, 1'b0, GC, 1'b1);
        recv("j3_rep_a", 8'h01, GA);
        recv("j3_rep_b", 8'h01, GB);
        recv("j3_rep_c", 8'h01, GC);
        q_valid = 1'b1; q_mrc = 8'd0; q_group = 32'd0;
        cyc();
        q_valid = 1'b0;
        tx_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (tx_valid && cnt < 4) begin
                cap_g[cnt] = tx_group;
                cap_t[cnt] = i;
                cnt++;
            end
            cyc();
        end
        tx_ready = 1'b0;
        check("gq_count", cnt, 3);
        if (cnt == 3) begin
            check("gq_first", cap_g[0], GA);
            check("gq_second", cap_g[1], GB);
            check("gq_third", cap_g[2], GC);
            check("gq_gap1", cap_t[1] - cap_t[0], 2);
            check("gq_gap2", cap_t[2] - cap_t[1], 2);
        end

        // Group query to slot 1, then a second query keeping the smaller remaining time
        d1 = ref_delay(m_lfsr, 8'd100);
        q_valid = 1'b1; q_mrc = 8'd100; q_group = GB;
        cyc();
        check("q1_timer", {24'd0, dut.slot_timer[1]}, {24'd0, d1});
        check("q1_runs", {29'd0, dut.slot_run[2:0]}, 32'b010);
        d2 = ref_delay(m_lfsr, 8'd255);
        q_mrc = 8'd255;
        cyc();
        q_valid = 1'b0;
        check("q2_timer", {24'd0, dut.slot_timer[1]}, {24'd0, (d2 < d1) ? d2 : d1});
        tx_ready = 1'b1;
        cnt = 0; tcnt = 0; ticks_at = 0; cap_ty = 8'h00;
        for (int i = 0; i < 300; i++) begin
            if (tx_valid) begin
                if (cnt == 0) begin
                    cap_g[0] = tx_group;
                    cap_ty   = tx_type;
                    ticks_at = tcnt;
                end
                cnt++;
            end
            tick = (i % 2 == 0);
            if (tick) tcnt++;
            cyc();
        end
        tick = 1'b0;
        tx_ready = 1'b0;
        check("gq1_count", cnt, 1);
        check("gq1_group", cap_g[0], GB);
        check("gq1_type", {24'd0, cap_ty}, 32'h01);
        check("gq1_ticks", {31'd0, ticks_at <= 101}, 32'd1);

        // Leave takes priority over a waiting report; a second leave is refused
        command("join_d5", 1'b1, 1'b0, GD, 1'b1);
        q_valid = 1'b1; q_mrc = 8'd0; q_group = GC;
        cyc();
        q_valid = 1'b0; q_group = 32'd0;
        command("leave_a", 1'b0, 1'b1, GA, 1'b1);
        command("leave_b_busy", 1'b0, 1'b1, GB, 1'b0);
        check("leave_a_vld", {31'd0, dut.slot_vld[0]}, 32'd0);
        recv("s5_rep_d", 8'h01, GD);
        recv("s5_leave_a", 8'h02, GA);
        recv("s5_rep_c", 8'h01, GC);
        command("leave_absent", 1'b0, 1'b1, GA, 1'b0);

        // Reset during SEND drops the message and empties the table
        command("join_x", 1'b1, 1'b0, GX, 1'b1);
        wait_tx(10, f);
        check("s6_seen", {31'd0, f}, 32'd1);
        rst = 1'b0;
        #1;
        check("s6_rst_valid", {31'd0, tx_valid}, 32'd0);
        check("s6_rst_group", tx_group, 32'd0);
        cyc();
        rst = 1'b1;
        cyc();
        check("s6_table", {28'd0, dut.slot_vld}, 32'd0);
        command("join_leave", 1'b1, 1'b1, GA, 1'b0);
        no_tx("s6_no_tx", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
